// File: rtl/drbg_request_arbiter.sv
// Shares one Hash_DRBG generator among NUM_REQ consumers. Requests are served round-robin and each block is held for HOLD_CYCLES.
// Optional watchdog on the generator handshake: define DRBG_ARB_TIMEOUT_EN.
module drbg_request_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 256,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  gen_busy,
  input  logic [DATA_WIDTH-1:0] gen_data,
  input  logic                  gen_data_valid,
  output logic                  gen_next,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_REQ-1:0]    data_valid,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_DATA = 3'd3,
    DELIVER   = 3'd4
  } state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   clear_mask;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        rr_idx;
  logic                 rr_found;
  logic [HW-1:0]        hold;
  logic                 hold_done;
  logic                 wd_expired;
  int                   cand;

  // Round-robin pick: walk from last_grant+NUM_REQ down to last_grant+1 so the nearest pending requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      rr_found = rr_found | pending[IW'(cand)];
      rr_idx   = pending[IW'(cand)] ? IW'(cand) : rr_idx;
    end
  end

  assign hold_done  = (hold == HW'(HOLD_CYCLES - 1));
  assign clear_mask = ((state == DELIVER) && hold_done) ? grant : {NUM_REQ{1'b0}};

`ifdef DRBG_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] watchdog;

  assign wd_expired = ((state == WAIT_LOW) || (state == WAIT_DATA)) && (watchdog == WW'(TIMEOUT - 1));

  // Watchdog spans both wait states of one transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      watchdog <= '0;
    end else if (state == ISSUE) begin
      watchdog <= '0;
    end else if ((state == WAIT_LOW) || (state == WAIT_DATA)) begin
      watchdog <= watchdog + WW'(1);
    end else begin
      watchdog <= watchdog;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Request bookkeeping and transaction FSM; a req in the clearing cycle re-arms pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      data_valid  <= '0;
      data_out    <= '0;
      gen_next    <= 1'b0;
      hold        <= '0;
      timeout_err <= 1'b0;
    end else begin
      pending <= (pending & ~clear_mask) | req;
      case (state)
        IDLE: begin
          if (rr_found && !gen_busy) begin
            grant_idx <= rr_idx;
            grant     <= NUM_REQ'(1) << rr_idx;
            gen_next  <= 1'b1;
            state     <= ISSUE;
          end else begin
            gen_next <= 1'b0;
            state    <= IDLE;
          end
        end
        ISSUE: begin
          gen_next <= 1'b0;
          state    <= WAIT_LOW;
        end
        WAIT_LOW, WAIT_DATA: begin
          if (wd_expired) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_idx;
            grant       <= '0;
            state       <= IDLE;
          end else if (state == WAIT_LOW) begin
            state <= gen_data_valid ? WAIT_LOW : WAIT_DATA;
          end else if (gen_data_valid) begin
            data_out   <= gen_data;
            data_valid <= grant;
            hold       <= '0;
            state      <= DELIVER;
          end else begin
            state <= WAIT_DATA;
          end
        end
        DELIVER: begin
          if (hold_done) begin
            data_valid <= '0;
            last_grant <= grant_idx;
            grant      <= '0;
            state      <= IDLE;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          grant      <= '0;
          data_valid <= '0;
          gen_next   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drbg_request_arbiter.sv
// Randomized + directed bench for drbg_request_arbiter against a transaction-level reference model.
module tb_drbg_request_arbiter;
  localparam int N  = 2;
  localparam int W  = 256;
  localparam int H  = 4;
  localparam int TO = 20;

  localparam int P_IDLE = 0, P_ISSUE = 1, P_LOW = 2, P_DATA = 3, P_DELIV = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         gen_busy;
  logic [W-1:0] gen_data;
  logic         gen_data_valid;
  logic         gen_next;
  logic [W-1:0] data_out;
  logic [N-1:0] data_valid;
  logic [N-1:0] grant;
  logic         timeout_err;

  drbg_request_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .HOLD_CYCLES(H), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .gen_busy(gen_busy), .gen_data(gen_data),
    .gen_data_valid(gen_data_valid), .gen_next(gen_next), .data_out(data_out),
    .data_valid(data_valid), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which phase of a transaction we are in, who owns it, and what was captured.
  int           m_phase;
  bit   [N-1:0] m_pend;
  int           m_owner;
  int           m_last;
  int           m_held;
  int           m_waited;
  bit   [W-1:0] m_data;
  bit           m_terr;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] done_mask;
    done_mask = '0;
    if (reset) begin
      m_phase = P_IDLE; m_pend = '0; m_last = N - 1; m_data = '0; m_terr = 1'b0;
      m_held = 0; m_waited = 0; m_owner = 0;
    end else begin
      if (m_phase == P_IDLE) begin
        if (m_pend != '0 && !gen_busy) begin
          for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_last + k) % N] && m_phase == P_IDLE) begin
              m_owner = (m_last + k) % N;
              m_phase = P_ISSUE;
            end
          end
        end
      end else if (m_phase == P_ISSUE) begin
        m_phase = P_LOW; m_waited = 0;
      end else if (m_phase == P_LOW || m_phase == P_DATA) begin
`ifdef DRBG_ARB_TIMEOUT_EN
        if (m_waited == TO - 1) begin
          m_terr = 1'b1; m_last = m_owner; m_phase = P_IDLE;
        end else begin
`else
        begin
`endif
          m_waited++;
          if (m_phase == P_LOW && !gen_data_valid) m_phase = P_DATA;
          else if (m_phase == P_DATA && gen_data_valid) begin
            m_data = gen_data; m_held = 0; m_phase = P_DELIV;
          end
        end
      end else begin
        m_held++;
        if (m_held == H) begin
          done_mask[m_owner] = 1'b1;
          m_last = m_owner;
          m_phase = P_IDLE;
        end
      end
      m_pend = (m_pend & ~done_mask) | req;
    end
  endtask

  task automatic compare();
    logic [N-1:0] e_grant, e_dv;
    e_grant = (m_phase != P_IDLE) ? N'(1) << m_owner : '0;
    e_dv    = (m_phase == P_DELIV) ? N'(1) << m_owner : '0;
    chk("grant", W'(grant), W'(e_grant));
    chk("data_valid", W'(data_valid), W'(e_dv));
    chk("gen_next", W'(gen_next), W'(m_phase == P_ISSUE));
    chk("data_out", data_out, m_data);
    chk("timeout_err", W'(timeout_err), W'(m_terr));
    chk("dv_onehot", W'($countones(data_valid) <= 1), W'(1));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; gen_busy = 1'b0; gen_data_valid = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // Generator stand-in: valid rises 'lat' cycles after gen_next and stays for 3 cycles.
  int resp_cnt = 0;
  task automatic respond(input int lat);
    if (gen_next) resp_cnt = 1;
    else if (resp_cnt > 0) resp_cnt++;
    gen_data_valid = (resp_cnt >= lat) && (resp_cnt < lat + 3);
  endtask

  logic [W-1:0] blk_a, blk_b, blk_old;
  logic [N-1:0] seen[$];
  int nv, pulses, mode, since;
  logic [N-1:0] prev_dv;

  initial begin
    blk_a   = {8{32'hA5A5_0001}};
    blk_b   = {8{32'hB0B0_0002}};
    blk_old = {8{32'h0DD0_0003}};
    gen_data = blk_a;
    do_reset();
    chk("reset_grant", W'(grant), W'(0));
    chk("reset_data_out", data_out, W'(0));

    // Single request, generator answers 5 cycles after gen_next.
    req = 2'b01; cyc(); req = 2'b00; cyc();
    chk("single_gen_next_latency", W'(gen_next), W'(1));
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      gen_data_valid = (i >= 4 && i < 7);
      cyc();
      if (data_valid == 2'b01) nv++;
    end
    chk("single_hold_cycles", W'(nv), W'(4));
    chk("single_data", data_out, blk_a);
    chk("single_grant_idle", W'(grant), W'(0));

    // Contention: both at once, requester 0 first.
    do_reset();
    seen.delete(); pulses = 0; prev_dv = '0; resp_cnt = 0;
    req = 2'b11; cyc(); req = 2'b00;
    for (int i = 0; i < 80; i++) begin
      respond(5); cyc();
      if (gen_next) pulses++;
      if (data_valid != '0 && prev_dv == '0) seen.push_back(data_valid);
      prev_dv = data_valid;
    end
    chk("contention_pulses", W'(pulses), W'(2));
    chk("contention_count", W'(seen.size()), W'(2));
    if (seen.size() == 2) begin
      chk("contention_first", W'(seen[0]), W'(2'b01));
      chk("contention_second", W'(seen[1]), W'(2'b10));
    end

    // Stale valid across gen_next must be ignored.
    do_reset();
    gen_data = blk_old; gen_data_valid = 1'b1; since = -1;
    req = 2'b01; cyc(); req = 2'b00;
    for (int i = 0; i < 30; i++) begin
      if (gen_next) since = 0;
      else if (since >= 0) since++;
      gen_data_valid = (since < 3) || (since >= 5);
      gen_data = (since >= 5) ? blk_b : blk_old;
      cyc();
    end
    chk("stale_data_b", data_out, blk_b);

    // Busy hold-off.
    do_reset();
    gen_busy = 1'b1; pulses = 0;
    req = 2'b10; cyc(); req = 2'b00;
    for (int i = 0; i < 10; i++) begin cyc(); if (gen_next) pulses++; end
    chk("busy_no_gen_next", W'(pulses), W'(0));
    gen_busy = 1'b0; cyc();
    chk("busy_release_gen_next", W'(gen_next), W'(1));
    chk("busy_grant", W'(grant), W'(2'b10));

    // Re-request in the final DELIVER cycle.
    do_reset();
    resp_cnt = 0; nv = 0; pulses = 0;
    req = 2'b01; cyc(); req = 2'b00;
    for (int i = 0; i < 60; i++) begin
      respond(3);
      req = (nv == 4) ? 2'b01 : 2'b00;
      cyc();
      if (data_valid == 2'b01) nv++;
      if (gen_next) pulses++;
    end
    chk("rerequest_second_txn", W'(pulses), W'(2));

    // Reset in WAIT_DATA aborts the grant.
    do_reset();
    gen_data_valid = 1'b0; since = -1;
    req = 2'b01; cyc(); req = 2'b00;
    for (int i = 0; i < 20 && since < 3; i++) begin
      if (gen_next) since = 0; else if (since >= 0) since++;
      cyc();
    end
    chk("abort_reached_wait", W'(since), W'(3));
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("abort_grant", W'(grant), W'(0));
    chk("abort_data_out", data_out, W'(0));
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      gen_data_valid = 1'(i % 2); cyc();
      if (data_valid != '0) nv++;
    end
    chk("abort_no_delivery", W'(nv), W'(0));

`ifdef DRBG_ARB_TIMEOUT_EN
    // Watchdog: valid never drops, so WAIT_LOW cannot progress.
    do_reset();
    gen_data_valid = 1'b1;
    req = 2'b01; cyc(); req = 2'b00;
    for (int i = 0; i < 2 + TO; i++) cyc();
    chk("timeout_flag", W'(timeout_err), W'(1));
`endif

    // Randomized traffic.
    do_reset();
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) mode = $urandom_range(0, 3);
      reset          = ($urandom_range(0, 499) == 0);
      req            = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      gen_busy       = ($urandom_range(0, 3) == 0);
      gen_data       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      gen_data_valid = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
